i_term_sat: RTL

I_TERM_SAT -- requirements
Module: i_term_sat

---
 rtl/i_term_sat.sv | 125 ++++++++++++
 1 files changed

// File: rtl/i_term_sat.sv
// -----------------------------------------------------------------------------
// i_term_sat -- saturating, decimated integrator producing the I term of a
// PI-style control loop.
//
// Every DECIM-th qualifying error strobe (err_vld with moving=1, freeze=0) adds
// the sign-extended error sample to a signed accumulator. The sum is formed one
// bit wider than the accumulator, so it cannot wrap before it is clamped to
// +/-ACC_LIM. The top OUT_W bits of the new accumulator value are registered as
// I_term, and i_vld pulses in the same cycle that I_term changes.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   err_vld  in   one-cycle strobe, new err_sat sample
//   err_sat  in   ERR_W signed error sample (already saturated upstream)
//   moving   in   1 = integrate, 0 = clear integrator state
//   freeze   in   1 = hold accumulator, decimation count and outputs
//   I_term   out  OUT_W signed integral term (registered)
//   i_vld    out  one-cycle pulse, I_term updated
//   sat      out  sticky flag, accumulator clamped since last clear
//
// Parameter legality: ACC_W > ERR_W, OUT_W <= ACC_W,
// 0 < ACC_LIM <= 2^(ACC_W-1)-1, and DECIM in 1..255.
// -----------------------------------------------------------------------------
module i_term_sat #(
   parameter int ERR_W   = 10,
   parameter int ACC_W   = 16,
   parameter int OUT_W   = 9,
   parameter int ACC_LIM = 32767,
   parameter int DECIM   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    err_vld,
   input  logic signed [ERR_W-1:0] err_sat,
   input  logic                    moving,
   input  logic                    freeze,
   output logic signed [OUT_W-1:0] I_term,
   output logic                    i_vld,
   output logic                    sat
);

   // Clamp limits held at ACC_W+1 bits so they compare directly with the
   // unwrapped sum.
   localparam logic signed [ACC_W:0] LIM_P = $signed((ACC_W+1)'(ACC_LIM));
   localparam logic signed [ACC_W:0] LIM_N = -LIM_P;
   localparam logic [7:0]            DCNT_LAST = 8'(DECIM - 1);

   logic signed [ACC_W-1:0] acc_reg,   acc_next;
   logic        [7:0]       dcnt_reg,  dcnt_next;
   logic signed [OUT_W-1:0] iterm_reg, iterm_next;
   logic                    ivld_reg,  ivld_next;
   logic                    sat_reg,   sat_next;

   logic signed [ACC_W:0]   err_ext;
   logic signed [ACC_W:0]   sum;

   // Sign-extend the error sample to the widened sum width.
   assign err_ext[ERR_W-1:0] = err_sat;
   genvar gi;
   generate
      for (gi = ERR_W; gi <= ACC_W; gi++) begin : g_sext
         assign err_ext[gi] = err_sat[ERR_W-1];
      end
   endgenerate

   assign sum = {acc_reg[ACC_W-1], acc_reg} + err_ext;

   always_comb begin
      acc_next   = acc_reg;
      dcnt_next  = dcnt_reg;
      iterm_next = iterm_reg;
      ivld_next  = 1'b0;
      sat_next   = sat_reg;

      if (!moving) begin
         // Clearing takes priority over freeze and integration.
         acc_next   = '0;
         dcnt_next  = '0;
         iterm_next = '0;
         sat_next   = 1'b0;
      end else if (freeze) begin
         // Hold everything; i_vld stays low.
      end else if (err_vld) begin
         if (dcnt_reg == DCNT_LAST) begin
            dcnt_next = '0;
            ivld_next = 1'b1;
            if (sum > LIM_P) begin
               acc_next = LIM_P[ACC_W-1:0];
               sat_next = 1'b1;
            end else if (sum < LIM_N) begin
               acc_next = LIM_N[ACC_W-1:0];
               sat_next = 1'b1;
            end else begin
               acc_next = sum[ACC_W-1:0];
            end
            // Arithmetic truncation: keep the top OUT_W bits of the new value.
            iterm_next = acc_next[ACC_W-1 -: OUT_W];
         end else begin
            dcnt_next = dcnt_reg + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg   <= '0;
         dcnt_reg  <= '0;
         iterm_reg <= '0;
         ivld_reg  <= 1'b0;
         sat_reg   <= 1'b0;
      end else begin
         acc_reg   <= acc_next;
         dcnt_reg  <= dcnt_next;
         iterm_reg <= iterm_next;
         ivld_reg  <= ivld_next;
         sat_reg   <= sat_next;
      end
   end

   assign I_term = iterm_reg;
   assign i_vld  = ivld_reg;
   assign sat    = sat_reg;

endmodule
